// File: rtl/digital_loop_filter_pkg.sv
// -----------------------------------------------------------------------------
// dlf_pkg
// Shared types and helpers for the digital loop filter.
//   lock_state_e : lock-detector states (IDLE, ACQ, LOCKED)
//   calc_t       : wide signed type used for every intermediate filter sum
//   clamp_res_t  : clamped value plus a flag saying whether clamping occurred
//   sclamp()     : signed clamp of a calc_t value into [lo, hi]
// -----------------------------------------------------------------------------
package dlf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  // Every intermediate sum is carried at this width. It must be at least
  // Nout+FRAC+2 bits so an integrator at full scale plus the largest
  // shifted error can never wrap before it is clamped.
  localparam int unsigned CALC_W = 32;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  clipped;
  } clamp_res_t;

  // Signed clamp into [lo, hi]; clipped is set when either bound was applied.
  function automatic clamp_res_t sclamp(input calc_t x, input calc_t lo, input calc_t hi);
    clamp_res_t r;
    r.value   = x;
    r.clipped = 1'b0;
    if (x < lo) begin
      r.value   = lo;
      r.clipped = 1'b1;
    end else if (x > hi) begin
      r.value   = hi;
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/digital_loop_filter_lock_detect.sv
// -----------------------------------------------------------------------------
// lock_detect
// Lock indicator for the loop filter. A sample is in-lock when |e_q| <=
// LOCK_TOL. LOCK_CNT consecutive in-lock samples declare lock; UNLOCK_CNT
// consecutive out-of-lock samples drop it. Deasserting en forces IDLE.
// Ports:
//   clk_ref : clock
//   rstn    : synchronous active-low reset
//   en      : loop enable (live input, wins over any lock transition)
//   e_q     : registered timing error (signed Nbit)
//   e_vld   : e_q holds a fresh sample this cycle
//   locked  : registered lock flag, high exactly while the state is LOCKED
// -----------------------------------------------------------------------------
module lock_detect
  import dlf_pkg::*;
#(
  parameter int Nbit       = 4,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                   clk_ref,
  input  logic                   rstn,
  input  logic                   en,
  input  logic signed [Nbit-1:0] e_q,
  input  logic                   e_vld,
  output logic                   locked
);

  localparam int MAX_CNT = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int AW      = Nbit + 1;

  localparam logic [CW-1:0] LOCK_CNT_C   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] UNLOCK_CNT_C = CW'(UNLOCK_CNT);
  localparam logic [AW-1:0] TOL_C        = AW'(LOCK_TOL);

  lock_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_locked;

  logic [AW-1:0] w_e_wide;
  logic [AW-1:0] w_abs;
  logic          w_in_lock;
  logic [CW-1:0] w_cnt_inc;

  // One extra bit so that the most negative code has a representable magnitude.
  assign w_e_wide  = {e_q[Nbit-1], e_q};
  assign w_abs     = w_e_wide[AW-1] ? (~w_e_wide + 1'b1) : w_e_wide;
  assign w_in_lock = (w_abs <= TOL_C);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_ref) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (!en) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (e_vld) begin
      case (r_state)
        // The sample that wakes the detector already counts toward lock.
        IDLE: begin
          r_state  <= ACQ;
          r_cnt    <= w_in_lock ? CW'(1) : '0;
          r_locked <= 1'b0;
        end
        ACQ: begin
          if (w_in_lock) begin
            if (w_cnt_inc >= LOCK_CNT_C) begin
              r_state  <= LOCKED;
              r_cnt    <= '0;
              r_locked <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        LOCKED: begin
          if (!w_in_lock) begin
            if (w_cnt_inc >= UNLOCK_CNT_C) begin
              r_state  <= ACQ;
              r_cnt    <= '0;
              r_locked <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked = r_locked;

endmodule

// File: rtl/digital_loop_filter.sv
// -----------------------------------------------------------------------------
// digital_loop_filter
// Proportional-integral loop filter between a TDC and a DCO.
//   stage 1: tdc_in -> e_q (captured while en=1), e_vld = en
//   stage 2: integ  <= clamp(integ + (e_q <<< KI_SHIFT))
//            dco    <= clamp((integ_next >> FRAC) + (e_q <<< KP_SHIFT))
// Ports:
//   clk_ref    : reference clock (only clock)
//   rstn       : synchronous active-low reset
//   en         : loop enable
//   tdc_in     : signed Nbit timing error
//   dco_code   : unsigned Nout DCO control word
//   code_valid : dco_code was updated on this edge
//   locked     : lock indicator from lock_detect
//   sat        : integrator or output clamp was active on this update
// -----------------------------------------------------------------------------
module digital_loop_filter
  import dlf_pkg::*;
#(
  parameter int Nbit       = 4,
  parameter int Nout       = 10,
  parameter int FRAC       = 4,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 0,
  parameter int CODE_INIT  = 512,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                   clk_ref,
  input  logic                   rstn,
  input  logic                   en,
  input  logic signed [Nbit-1:0] tdc_in,
  output logic        [Nout-1:0] dco_code,
  output logic                   code_valid,
  output logic                   locked,
  output logic                   sat
);

  localparam int IW = Nout + FRAC;

  localparam calc_t INTEG_MAX = calc_t'((64'sd1 <<< IW) - 64'sd1);
  localparam calc_t CODE_MAX  = calc_t'((64'sd1 <<< Nout) - 64'sd1);
  localparam calc_t ZERO_C    = '0;

  localparam logic [IW-1:0]   INTEG_INIT = IW'(CODE_INIT << FRAC);
  localparam logic [Nout-1:0] CODE_INIT_C = Nout'(CODE_INIT);

  // Stage 1 registers
  logic signed [Nbit-1:0] r_e_q;
  logic                   r_e_vld;

  // Stage 2 registers
  logic [IW-1:0]   r_integ;
  logic [Nout-1:0] r_dco;
  logic            r_code_valid;
  logic            r_sat;

  // Datapath (all in the wide signed domain so nothing wraps before clamping)
  calc_t      w_e_ext;
  calc_t      w_integ_ext;
  calc_t      w_integ_sum;
  calc_t      w_prop_sum;
  clamp_res_t w_integ_clamp;
  clamp_res_t w_code_clamp;

  assign w_e_ext       = {{(CALC_W-Nbit){r_e_q[Nbit-1]}}, r_e_q};
  assign w_integ_ext   = {{(CALC_W-IW){1'b0}}, r_integ};
  assign w_integ_sum   = w_integ_ext + (w_e_ext <<< KI_SHIFT);
  assign w_integ_clamp = sclamp(w_integ_sum, ZERO_C, INTEG_MAX);
  // The clamped integrator is non-negative, so the arithmetic shift is a plain floor.
  assign w_prop_sum    = (w_integ_clamp.value >>> FRAC) + (w_e_ext <<< KP_SHIFT);
  assign w_code_clamp  = sclamp(w_prop_sum, ZERO_C, CODE_MAX);

  // Stage 1: error capture
  always_ff @(posedge clk_ref) begin
    if (!rstn) begin
      r_e_q   <= '0;
      r_e_vld <= 1'b0;
    end else begin
      r_e_vld <= en;
      if (en) begin
        r_e_q <= tdc_in;
      end
    end
  end

  // Stage 2: integrator and output word. A sample captured on the last
  // enabled edge is still applied on the following edge; after that the
  // state holds until new samples arrive.
  always_ff @(posedge clk_ref) begin
    if (!rstn) begin
      r_integ      <= INTEG_INIT;
      r_dco        <= CODE_INIT_C;
      r_code_valid <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_code_valid <= r_e_vld;
      r_sat        <= 1'b0;
      if (r_e_vld) begin
        r_integ <= w_integ_clamp.value[IW-1:0];
        r_dco   <= w_code_clamp.value[Nout-1:0];
        r_sat   <= w_integ_clamp.clipped | w_code_clamp.clipped;
      end
    end
  end

  lock_detect #(
    .Nbit       (Nbit),
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock_detect (
    .clk_ref (clk_ref),
    .rstn    (rstn),
    .en      (en),
    .e_q     (r_e_q),
    .e_vld   (r_e_vld),
    .locked  (locked)
  );

  assign dco_code   = r_dco;
  assign code_valid = r_code_valid;
  assign sat        = r_sat;

endmodule
